// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin packet arbiter sharing one uart_tx serializer between NUM_REQ byte-stream requesters.
// Latency: 1 cycle from req_valid_i in IDLE to gnt_o; bytes forward combinationally while granted.
// Backpressure: req_ready_o of the granted requester follows tx_ready_i; all others see 0. Build option: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int TIMEOUT_W = 16,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cfg_en_i,
   input  logic [TIMEOUT_W-1:0]   cfg_timeout_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [8*NUM_REQ-1:0]   req_data_i,
   input  logic [NUM_REQ-1:0]     req_last_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   output logic [NUM_REQ-1:0]     gnt_o,
   output logic [ID_W-1:0]        gnt_id_o,
   output logic [7:0]             tx_data_o,
   output logic                   tx_valid_o,
   input  logic                   tx_ready_i,
   input  logic                   tx_busy_i,
   output logic                   timeout_o
);

   typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic            win_vld;
   logic [ID_W-1:0] win_id;
   logic            sel_vld;
   logic            sel_last;
   logic [7:0]      sel_dat;
   logic            xfer;
   logic            xfer_last;

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] stall_cnt;
   logic                 timeout_q;
   logic                 stall_hit;

   assign stall_hit = (cfg_timeout_i != '0) && (stall_cnt == cfg_timeout_i);
   assign timeout_o = timeout_q;
`else
   // Without the timeout a stalled requester keeps the grant until cfg_en_i drops.
   logic unused_cfg_timeout;
   assign unused_cfg_timeout = ^cfg_timeout_i;
   assign timeout_o          = 1'b0;
`endif

   // Scan upward from ptr with wrap; iterating downward lets the nearest index win.
   always_comb begin
      int              idx;
      logic [ID_W-1:0] cand;
      win_vld = 1'b0;
      win_id  = '0;
      idx     = 0;
      cand    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx  = (int'(ptr) + i) % NUM_REQ;
         cand = ID_W'(idx);
         if (req_valid_i[cand]) begin
            win_vld = 1'b1;
            win_id  = cand;
         end
      end
   end

   // Forward the granted requester to the serializer; valid is gated by ready because uart_tx samples on valid alone.
   always_comb begin
      sel_vld     = 1'b0;
      sel_last    = 1'b0;
      sel_dat     = '0;
      tx_data_o   = '0;
      tx_valid_o  = 1'b0;
      req_ready_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_id_o == ID_W'(k)) begin
            sel_vld  = req_valid_i[k];
            sel_last = req_last_i[k];
            sel_dat  = req_data_i[8*k +: 8];
         end
      end
      if (state == XFER) begin
         tx_data_o   = sel_dat;
         tx_valid_o  = sel_vld & tx_ready_i;
         req_ready_o = gnt_o & {NUM_REQ{tx_ready_i}};
      end
   end

   assign xfer      = tx_valid_o;
   assign xfer_last = xfer & sel_last;

   // Grant FSM: hold the grant for a whole packet, then until the last frame has left the line.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         ptr      <= '0;
         gnt_o    <= '0;
         gnt_id_o <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         stall_cnt <= '0;
         timeout_q <= 1'b0;
`endif
      end else if (!cfg_en_i) begin
         // Disable abandons any packet; ptr is kept so fairness survives the pause.
         state    <= IDLE;
         gnt_o    <= '0;
         gnt_id_o <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         stall_cnt <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (win_vld) begin
                  gnt_o    <= NUM_REQ'(1) << win_id;
                  gnt_id_o <= win_id;
                  state    <= XFER;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
               end
            end
            XFER: begin
               if (xfer_last) begin
                  state <= DRAIN;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (stall_hit) begin
                  timeout_q <= 1'b1;
                  state     <= DRAIN;
               end
               // Count only cycles where the serializer could take a byte but the owner has none.
               if (xfer) begin
                  stall_cnt <= '0;
               end else if (tx_ready_i && !sel_vld && (stall_cnt != '1)) begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
`endif
            end
            DRAIN: begin
               if (!tx_busy_i) begin
                  state    <= IDLE;
                  gnt_o    <= '0;
                  gnt_id_o <= '0;
                  ptr      <= (gnt_id_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_o + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a uart_tx model drive the DUT,
// every byte leaving on the wire is compared against a scoreboard of {requester, data}.
// Timeout scenario is exercised only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int TIMEOUT_W = 16;
   localparam int FRAME     = 6;

   logic                   clk_i = 1'b0;
   logic                   rst_i = 1'b1;
   logic                   cfg_en_i = 1'b0;
   logic [TIMEOUT_W-1:0]   cfg_timeout_i = '0;
   logic [NUM_REQ-1:0]     req_valid_i;
   logic [8*NUM_REQ-1:0]   req_data_i;
   logic [NUM_REQ-1:0]     req_last_i;
   logic [NUM_REQ-1:0]     req_ready_o;
   logic [NUM_REQ-1:0]     gnt_o;
   logic [1:0]             gnt_id_o;
   logic [7:0]             tx_data_o;
   logic                   tx_valid_o;
   logic                   tx_ready_i;
   logic                   tx_busy_i;
   logic                   timeout_o;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_W(TIMEOUT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_timeout_i(cfg_timeout_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
      .req_ready_o(req_ready_o), .gnt_o(gnt_o), .gnt_id_o(gnt_id_o),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .tx_busy_i(tx_busy_i), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] rq [NUM_REQ][$];
   logic [9:0] exp_q [$];
   int bsy = 0;
   bit hold_rdy = 1'b0;
   int to_pulses = 0;
   int vld_viol = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_byte(input int k, input logic [7:0] d, input bit last, input bit exp_it);
      rq[k].push_back({last, d});
      if (exp_it) exp_q.push_back({2'(k), d});
   endtask

   // Requester sources and uart_tx model; outputs sampled at negedge, inputs updated 1 after posedge.
   initial begin
      logic [NUM_REQ-1:0] rf;
      logic               uf;
      logic [9:0]         cap;
      logic [9:0]         e;
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
      tx_ready_i  = 1'b0;
      tx_busy_i   = 1'b0;
      forever begin
         @(negedge clk_i);
         rf  = req_valid_i & req_ready_o;
         uf  = tx_valid_o & tx_ready_i;
         cap = {gnt_id_o, tx_data_o};
         if (tx_valid_o && !tx_ready_i) vld_viol++;
         if (timeout_o) to_pulses++;
         @(posedge clk_i);
         #1;
         if (rst_i) begin
            bsy = 0;
         end else begin
            if (uf) begin
               bsy = FRAME;
               e = 'x;
               if (exp_q.size() != 0) e = exp_q.pop_front();
               check("wire_byte", 32'(cap), 32'(e));
            end else if (bsy > 0) begin
               bsy--;
            end
            for (int k = 0; k < NUM_REQ; k++)
               if (rf[k] && rq[k].size() != 0) void'(rq[k].pop_front());
         end
         for (int k = 0; k < NUM_REQ; k++) begin
            req_valid_i[k] = (rq[k].size() != 0);
            req_data_i[8*k +: 8] = (rq[k].size() != 0) ? rq[k][0][7:0] : 8'h00;
            req_last_i[k] = (rq[k].size() != 0) ? rq[k][0][8] : 1'b0;
         end
         tx_busy_i  = (bsy != 0);
         tx_ready_i = (bsy == 0) && !hold_rdy && !rst_i;
      end
   end

   task automatic do_reset();
      cfg_en_i = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) rq[k].delete();
      exp_q.delete();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("rst_gnt", gnt_o, 0);
      check("rst_gnt_id", gnt_id_o, 0);
      check("rst_txv", tx_valid_o, 0);
      check("rst_rdy", req_ready_o, 0);
      check("rst_timeout", timeout_o, 0);
      rst_i = 1'b0;
      cfg_en_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      bit ok;
      bit empty;
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk_i);
         empty = 1'b1;
         for (int k = 0; k < NUM_REQ; k++) if (rq[k].size() != 0) empty = 1'b0;
         ok = empty && (exp_q.size() == 0) && (gnt_o == '0) && !tx_busy_i;
      end
      check(tag, ok, 1);
   endtask

   task automatic wait_gnt(input string tag, input int max_cyc);
      int i;
      for (i = 0; i < max_cyc && gnt_o == '0; i++) @(negedge clk_i);
      check(tag, (gnt_o != '0), 1);
   endtask

   initial begin
      do_reset();

      // Single packet from requester 2 with ptr at 0.
      push_byte(2, 8'hA5, 1'b0, 1'b1);
      push_byte(2, 8'h3C, 1'b1, 1'b1);
      for (int i = 0; i < 20 && !req_valid_i[2]; i++) @(negedge clk_i);
      @(posedge clk_i);
      #2;
      check("t1_gnt", gnt_o, 4'b0100);
      check("t1_gnt_id", gnt_id_o, 2);
      check("t1_txv", tx_valid_o, 1);
      check("t1_txd", tx_data_o, 8'hA5);
      wait_done("t1_done", 200);

      // Contention from reset: grant order 0,1,2,3.
      do_reset();
      for (int k = 0; k < NUM_REQ; k++) begin
         push_byte(k, 8'(16*k + 1), 1'b0, 1'b1);
         push_byte(k, 8'(16*k + 2), 1'b1, 1'b1);
      end
      wait_done("t2_done", 400);

      // Rotation: 1 and 3 continuously valid alternate 1,3,1,3,...
      for (int r = 0; r < 3; r++) begin
         push_byte(1, 8'(8'h80 + 2*r), 1'b0, 1'b1);
         push_byte(1, 8'(8'h81 + 2*r), 1'b1, 1'b1);
         push_byte(3, 8'(8'hB0 + 2*r), 1'b0, 1'b1);
         push_byte(3, 8'(8'hB1 + 2*r), 1'b1, 1'b1);
      end
      wait_done("t3_done", 600);

      // Serializer not ready for 20 cycles while granted.
      hold_rdy = 1'b1;
      push_byte(0, 8'hC1, 1'b0, 1'b1);
      push_byte(0, 8'hC2, 1'b1, 1'b1);
      wait_gnt("t4_gnt_seen", 20);
      check("t4_gnt", gnt_o, 4'b0001);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         check("t4_txv_hold", tx_valid_o, 0);
         check("t4_rdy_hold", req_ready_o, 0);
      end
      hold_rdy = 1'b0;
      wait_done("t4_done", 200);

      // Disable after byte 1 of 3; remainder goes out as a new grant.
      push_byte(2, 8'h11, 1'b0, 1'b1);
      push_byte(2, 8'h22, 1'b0, 1'b0);
      push_byte(2, 8'h33, 1'b1, 1'b0);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_i);
      check("t5_byte1", exp_q.size(), 0);
      cfg_en_i = 1'b0;
      @(posedge clk_i);
      #2;
      check("t5_gnt_off", gnt_o, 0);
      check("t5_txv_off", tx_valid_o, 0);
      check("t5_rdy_off", req_ready_o, 0);
      repeat (10) @(negedge clk_i);
      exp_q.push_back({2'd2, 8'h22});
      exp_q.push_back({2'd2, 8'h33});
      cfg_en_i = 1'b1;
      wait_gnt("t5_regnt_seen", 20);
      check("t5_regnt", gnt_o, 4'b0100);
      wait_done("t5_done", 200);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Requester 0 stalls after one byte; the timeout hands the line to requester 1.
      cfg_timeout_i = 16'd8;
      to_pulses = 0;
      push_byte(0, 8'h55, 1'b0, 1'b1);
      push_byte(1, 8'h66, 1'b0, 1'b1);
      push_byte(1, 8'h77, 1'b1, 1'b1);
      wait_done("t6_done", 300);
      check("t6_pulses", to_pulses, 1);
`else
      check("no_timeout", to_pulses, 0);
`endif

      check("valid_without_ready", vld_viol, 0);
      check("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter that shares one `uart_tx` serializer between `NUM_REQ` byte-stream requesters. It sits between the requester FIFOs and the `uart_tx` input handshake (`tx_data_i`/`tx_valid_i`/`tx_ready_o`/`busy_o`). A grant is held for a whole packet, from first byte until the `last` byte's frame has left the line, so packets from different requesters never interleave on the wire.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, legal 2..8.
- `TIMEOUT_W`, 16: width of the stall-timeout counter and `cfg_timeout_i`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. **Reset is asynchronous and active-high.** One clock domain only.
- `cfg_en_i`, in, 1: arbiter enable. Tie to the same enable as `uart_tx`.
- `cfg_timeout_i`, in, `TIMEOUT_W`: stall limit in cycles. 0 disables the timeout. Ignored when `UART_TX_ARB_TIMEOUT_EN` is not defined.
- `req_valid_i`, in, `NUM_REQ`: per-requester byte valid.
- `req_data_i`, in, `8*NUM_REQ`: requester k uses bits `[8k+7:8k]`.
- `req_last_i`, in, `NUM_REQ`: current byte is the last byte of the packet.
- `req_ready_o`, out, `NUM_REQ`: byte accepted when `req_valid_i[k] & req_ready_o[k]`.
- `gnt_o`, out, `NUM_REQ`: one-hot grant. All zero when no grant is held.
- `gnt_id_o`, out, `$clog2(NUM_REQ)`: index of the granted requester.
- `tx_data_o`, out, 8: to `uart_tx.tx_data_i`.
- `tx_valid_o`, out, 1: to `uart_tx.tx_valid_i`.
- `tx_ready_i`, in, 1: from `uart_tx.tx_ready_o`.
- `tx_busy_i`, in, 1: from `uart_tx.busy_o`.
- `timeout_o`, out, 1: one-cycle pulse when a grant is revoked by the timeout.

## Operation
- States: IDLE, XFER, DRAIN. Round-robin pointer `ptr` ranges 0..NUM_REQ-1.
- IDLE
  - If `cfg_en_i` is high and any `req_valid_i` is set, pick the winner: the first set index scanning upward from `ptr` and wrapping.
  - Register the winner into `gnt_o`/`gnt_id_o` and go to XFER.
- XFER
  - Combinational forwarding: `tx_data_o = req_data_i[gnt]` and `tx_valid_o = req_valid_i[gnt] & tx_ready_i`.
  - `tx_valid_o` must never be high while `tx_ready_i` is low, because `uart_tx` samples data on valid alone.
  - `req_ready_o[gnt] = tx_ready_i`. All other `req_ready_o` bits are 0.
  - A transfer with `req_last_i[gnt]` high moves the state to DRAIN.
- DRAIN
  - Hold the grant, keep `tx_valid_o` at 0, and wait for `tx_busy_i == 0`.
  - On exit, clear the grant, set `ptr = (gnt_id + 1) mod NUM_REQ`, and go to IDLE.
- `cfg_en_i` low in any state:
  - Next edge forces IDLE with the grant cleared. `ptr` is unchanged.
  - A packet in progress is abandoned. No byte is lost or duplicated beyond the bytes already accepted.
- A requester that drops `req_valid_i` mid-packet keeps the grant; the arbiter waits for it.
- Reset values: all outputs 0, `ptr` = 0, state IDLE.

## Timing
- Arbitration latency is 1 cycle: valid seen in IDLE at edge n gives `gnt_o` at n+1.
- `tx_valid_o` can be high in cycle n+1 if `tx_ready_i` is high.
- `uart_tx` drops `tx_ready_i` the cycle after a transfer. The arbiter needs no extra gap.
- DRAIN is entered the cycle after the last transfer, when `tx_busy_i` is already 1. It exits on the first cycle `tx_busy_i` reads 0. IDLE then arbitrates on that same edge, so the next grant appears one cycle later.
- Back-to-back packets from one requester: that requester loses priority to any other valid requester at the next arbitration.
- Reset mid-operation: asynchronous clear to the reset values. `tx_valid_o` drops immediately.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - In XFER, a `TIMEOUT_W` counter increments each cycle where `tx_ready_i` is high and `req_valid_i[gnt]` is low.
  - The counter clears on every transfer and on entry to XFER.
  - When the counter equals `cfg_timeout_i` (nonzero), pulse `timeout_o` for 1 cycle and go to DRAIN; the rotate rule applies.
  - The counter saturates and does not wrap.
- Not defined:
  - No counter is built and `timeout_o` is tied to 0.
  - A stalled requester holds the grant until `cfg_en_i` drops.

## Test plan
- Single packet: requester 2 sends 0xA5, 0x3C (last) with `ptr` = 0. Expect `gnt_o` = 4'b0100 one cycle after valid. The UART receives 0xA5 then 0x3C, and the grant clears after `tx_busy_i` falls.
- Contention: all 4 requesters send 2-byte packets from reset. Grant order 0, 1, 2, 3 with no interleaving on `tx_data_o`.
- Rotation: requesters 1 and 3 both valid continuously. Grants alternate 1, 3, 1, 3. Requester 1 is never granted twice in a row.
- Handshake: hold `tx_ready_i` low for 20 cycles during XFER. `tx_valid_o` and `req_ready_o` stay 0 throughout, and no byte is dropped.
- Disable mid-packet: drop `cfg_en_i` after byte 1 of 3. Next cycle state is IDLE and `gnt_o` = 0. On re-enable, the remaining bytes arbitrate as a new grant.
- Timeout (macro on): `cfg_timeout_i` = 8 and the granted requester stalls after byte 1. `timeout_o` pulses once after 8 ready-idle cycles, the grant rotates, and another requester's packet proceeds.
